muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit next to the register file: takes the two read operands, runs one op over

---
 rtl/muldiv_unit.sv | 128 ++++++++++++
 tb/tb_muldiv_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative shift-add multiplier / restoring divider with reg-file write-back strobe.
// Define MULDIV_SIGNED_EN to honour op[2] as a signed-operation select.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       rd_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             reg_write,
    output logic [4:0]       rd_out,
    output logic [WIDTH-1:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         op_q;
    logic [4:0]         rd_q;
    logic               busy_q, done_q, wr_q;
    logic [WIDTH-1:0]   result_q, m_q, acc_q, lo_q, acc_d, lo_d, res_d;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [WIDTH:0]     sum, shl, trial;
    logic [2*WIDTH-1:0] prod, step_mul, step_div;
    logic               launch;
    assign launch = (state_q == IDLE) && start && !flush;
    // acc holds the product high half / partial remainder; lo holds the multiplier / quotient bits
    assign sum      = {1'b0, acc_q} + {1'b0, m_q};
    assign shl      = {acc_q, lo_q[WIDTH-1]};
    assign trial    = shl - {1'b0, m_q};
    assign step_mul = lo_q[0] ? {sum, lo_q[WIDTH-1:1]} : {1'b0, acc_q, lo_q[WIDTH-1:1]};
    assign step_div = trial[WIDTH] ? {shl[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b0}
                                   : {trial[WIDTH-1:0], lo_q[WIDTH-2:0], 1'b1};
    assign {acc_d, lo_d} = op_q[1] ? step_div : step_mul;
`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, sa_q, bz_q;
    assign a_neg = op[2] & src_a[WIDTH-1];
    assign b_neg = op[2] & src_b[WIDTH-1];
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;
    assign prod  = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    // divide by zero keeps the all-ones quotient regardless of operand signs
    assign quo   = (neg_q && !bz_q) ? -lo_q : lo_q;
    assign rem   = sa_q ? -acc_q : acc_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            neg_q <= 1'b0;
            sa_q  <= 1'b0;
            bz_q  <= 1'b0;
        end else if (launch) begin
            neg_q <= a_neg ^ b_neg;
            sa_q  <= a_neg;
            bz_q  <= (src_b == '0);
        end
    end
`else
    logic unused_sign;
    assign unused_sign = op[2];
    assign a_mag = src_a;
    assign b_mag = src_b;
    assign prod  = {acc_q, lo_q};
    assign quo   = lo_q;
    assign rem   = acc_q;
`endif
    assign res_d = (op_q == 2'd0) ? prod[WIDTH-1:0] :
                   (op_q == 2'd1) ? prod[2*WIDTH-1:WIDTH] :
                   (op_q == 2'd2) ? quo : rem;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wr_q     <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            wr_q   <= 1'b0;
            case (state_q)
                IDLE: if (launch) begin
                    state_q <= BUSY;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    op_q    <= op[1:0];
                    rd_q    <= rd_in;
                    acc_q   <= '0;
                    m_q     <= op[1] ? b_mag : a_mag;
                    lo_q    <= op[1] ? a_mag : b_mag;
                end
                BUSY: if (flush) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end else begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        result_q <= res_d;
                        done_q   <= 1'b1;
                        wr_q     <= (rd_q != 5'd0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy      = busy_q;
    assign done      = done_q;
    assign reg_write = wr_q;
    assign rd_out    = rd_q;
    assign result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit, checked by a queue-based scoreboard and done-monitor.
module tb_muldiv_unit;
    localparam int W = 32;
    logic         clk = 1'b0, rst = 1'b0, start = 1'b0, flush = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] src_a = '0, src_b = '0;
    logic [4:0]   rd_in = '0;
    logic         busy, done, reg_write;
    logic [4:0]   rd_out;
    logic [W-1:0] result;
    int checks = 0, errors = 0, cyc = 0;
    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rd;
        logic         wr;
        int           at;
    } exp_t;
    exp_t q[$];

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .rd_in(rd_in), .flush(flush), .busy(busy), .done(done), .reg_write(reg_write),
        .rd_out(rd_out), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst && done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result %h rd %0d expected no done", result, rd_out);
            end else begin
                e = q.pop_front();
                chk("result", result, e.res);
                chk("rd_out", rd_out, e.rd);
                chk("reg_write", reg_write, e.wr);
                chk("latency", cyc, e.at);
            end
        end
    end

    task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] rd, input logic [W-1:0] r, input bit expect_done);
        @(negedge clk);
        op = o; src_a = a; src_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op = ~o; src_a = ~a; src_b = ~b; rd_in = ~rd;
        if (expect_done) q.push_back('{res: r, rd: rd, wr: (rd != 5'd0), at: cyc + W + 1});
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [4:0] rd, input logic [W-1:0] r);
        launch(o, a, b, rd, r, 1'b1);
        repeat (W + 2) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_result", result, 0);
        rst = 1'b1;

        run(3'b000, 32'd7, 32'd6, 5'd5, 32'd42);
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE);
        run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0001);
        run(3'b010, 32'd100, 32'd7, 5'd7, 32'd14);
        run(3'b011, 32'd100, 32'd7, 5'd8, 32'd2);
        run(3'b010, 32'h1234, 32'd0, 5'd9, 32'hFFFF_FFFF);
        run(3'b011, 32'h1234, 32'd0, 5'd10, 32'h1234);
        run(3'b000, 32'h1234_5678, 32'h10, 5'd11, 32'h2345_6780);
        run(3'b001, 32'h1234_5678, 32'h10, 5'd11, 32'h1);
        run(3'b000, 32'd2, 32'd3, 5'd0, 32'd6);

        launch(3'b000, 32'd3, 32'd5, 5'd12, 32'd15, 1'b1);
        chk("busy_after_launch", busy, 1);
        repeat (2) @(posedge clk);
        #1;
        op = 3'b010; src_a = 32'd100; src_b = 32'd7; rd_in = 5'd13; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (W) @(posedge clk);

        launch(3'b000, 32'd100, 32'd100, 5'd14, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        repeat (W + 4) @(posedge clk);
        #1;
        chk("flush_result_held", result, 32'd15);

        @(negedge clk);
        op = 3'b000; src_a = 32'd9; src_b = 32'd9; rd_in = 5'd1; start = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle_busy", busy, 0);
        repeat (W + 3) @(posedge clk);

        launch(3'b000, 32'd100, 32'd100, 5'd15, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midop_rst_busy", busy, 0);
        chk("midop_rst_done", done, 0);
        chk("midop_rst_reg_write", reg_write, 0);
        chk("midop_rst_rd_out", rd_out, 0);
        chk("midop_rst_result", result, 0);
        @(negedge clk) rst = 1'b1;
        repeat (W + 4) @(posedge clk);

        run(3'b010, 32'hFFFF_FFFF, 32'h10, 5'd16, 32'h0FFF_FFFF);
        run(3'b011, 32'hFFFF_FFFF, 32'h10, 5'd17, 32'hF);
`ifdef MULDIV_SIGNED_EN
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd18, 32'hFFFF_FFFD);
        run(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd19, 32'hFFFF_FFFF);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h8000_0000);
        run(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h0);
        run(3'b110, 32'hFFFF_FFFB, 32'd0, 5'd22, 32'hFFFF_FFFF);
        run(3'b111, 32'hFFFF_FFFB, 32'd0, 5'd23, 32'hFFFF_FFFB);
        run(3'b100, 32'hFFFF_FFFD, 32'd4, 5'd24, 32'hFFFF_FFF4);
        run(3'b101, 32'hFFFF_FFFD, 32'd4, 5'd25, 32'hFFFF_FFFF);
`else
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd18, 32'h7FFF_FFFC);
        run(3'b111, 32'hFFFF_FFF9, 32'd2, 5'd19, 32'h1);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0);
        run(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000);
        run(3'b100, 32'hFFFF_FFFD, 32'd4, 5'd24, 32'hFFFF_FFF4);
        run(3'b101, 32'hFFFF_FFFD, 32'd4, 5'd25, 32'h3);
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("pending_expected_done", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
